vector_mem_sequencer: RTL and testbench

// Sits between the execute-stage pipeline register and the data memory behind memory_module.

---
 rtl/vector_mem_sequencer.sv | 150 +++++++++++++++
 tb/tb_vector_mem_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vector_mem_sequencer.sv
// Splits 128-bit vector or 32-bit scalar memory requests into 32-bit beats on a
// synchronous word RAM. Reassembles load lanes and stalls the pipeline while busy.
module vector_mem_sequencer #(
  parameter int ADDR_W = 16,
  parameter int LANES  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic                req_vf,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LANES*32-1:0] req_wdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  output logic                rsp_valid,
  output logic [LANES*32-1:0] rsp_rdata,
  output logic                stall
);

  localparam int DW = LANES * 32;
  localparam int BW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {IDLE, WRITE, READ, RDRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic              vf_q, vf_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              rd_pend_q, rd_pend_d;
  logic [BW-1:0]     rd_lane_q, rd_lane_d;
  logic [DW-1:0]     asm_q, asm_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;

  logic [BW-1:0]     last_beat;
  logic [BW-1:0]     beat_nx;

  assign last_beat = vf_q ? BW'(LANES - 1) : '0;
  assign beat_nx   = beat_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    vf_d        = vf_q;
    wdata_d     = wdata_q;
    beat_d      = beat_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    // RAM read latency is one cycle: the word on mem_rdata belongs to the
    // address driven during the previous READ cycle.
    rd_pend_d   = (state_q == READ);
    rd_lane_d   = beat_q;
    asm_d       = asm_q;
    if (rd_pend_q) begin
      asm_d[int'(rd_lane_q)*32 +: 32] = mem_rdata;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          vf_d       = req_vf;
          wdata_d    = req_wdata;
          beat_d     = '0;
          mem_addr_d = req_addr;
          if (req_we) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = req_wdata[31:0];
            state_d     = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        if (beat_q == last_beat) begin
          mem_we_d = 1'b0;
          beat_d   = '0;
          state_d  = DONE;
        end else begin
          beat_d      = beat_nx;
          mem_addr_d  = mem_addr_q + 1'b1;
          mem_wdata_d = wdata_q[int'(beat_nx)*32 +: 32];
        end
      end
      READ: begin
        if (beat_q == last_beat) begin
          beat_d  = '0;
          state_d = RDRAIN;
        end else begin
          beat_d     = beat_nx;
          mem_addr_d = mem_addr_q + 1'b1;
        end
      end
      RDRAIN: begin
        rsp_rdata_d = vf_q ? asm_d : {{(DW-32){1'b0}}, mem_rdata};
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vf_q        <= 1'b0;
      wdata_q     <= '0;
      beat_q      <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_lane_q   <= '0;
      asm_q       <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      vf_q        <= vf_d;
      wdata_q     <= wdata_d;
      beat_q      <= beat_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rd_pend_q   <= rd_pend_d;
      rd_lane_q   <= rd_lane_d;
      asm_q       <= asm_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign stall     = (state_q != IDLE);
  assign rsp_valid = (state_q == DONE);
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer with a synchronous RAM model and a
// queue of expected response data.
module tb_vector_mem_sequencer;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         reqValid = 1'b0;
  logic         reqReady;
  logic         reqWe = 1'b0;
  logic         reqVf = 1'b0;
  logic [15:0]  reqAddr = '0;
  logic [127:0] reqWdata = '0;
  logic [15:0]  memAddr;
  logic         memWe;
  logic [31:0]  memWdata;
  logic [31:0]  memRdata = '0;
  logic         rspValid;
  logic [127:0] rspRdata;
  logic         stall;

  int checks = 0;
  int errors = 0;
  int accCnt = 0;
  int rspCnt = 0;
  logic [127:0] expQ[$];

  logic [31:0] ram [0:65535];

  vector_mem_sequencer #(.ADDR_W(16), .LANES(4)) dut (
    .clk(clk), .rst_n(rstN),
    .req_valid(reqValid), .req_ready(reqReady), .req_we(reqWe), .req_vf(reqVf),
    .req_addr(reqAddr), .req_wdata(reqWdata),
    .mem_addr(memAddr), .mem_we(memWe), .mem_wdata(memWdata), .mem_rdata(memRdata),
    .rsp_valid(rspValid), .rsp_rdata(rspRdata), .stall(stall)
  );

  always #5 clk = ~clk;

  // Word-addressed RAM with one cycle of read latency
  always @(posedge clk) begin
    if (memWe) ram[memAddr] <= memWdata;
    memRdata <= ram[memAddr];
  end

  always @(posedge clk) begin
    if (reqValid && reqReady) accCnt++;
    if (rspValid) rspCnt++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic we, input logic vf,
                               input logic [15:0] addr, input logic [127:0] wdata,
                               input logic [127:0] expData, input int expLat,
                               output int stallCnt);
    int lat;
    logic [127:0] want;
    @(negedge clk);
    checkOutput({tag, " ready"}, reqReady, 1'b1);
    reqWe = we; reqVf = vf; reqAddr = addr; reqWdata = wdata; reqValid = 1'b1;
    expQ.push_back(expData);
    @(negedge clk);
    reqValid = 1'b0;
    lat = 0;
    stallCnt = 0;
    while (!rspValid && lat < 64) begin
      if (stall) stallCnt++;
      @(negedge clk);
      lat++;
    end
    want = expQ.pop_front();
    checkOutput({tag, " rsp_valid"}, rspValid, 1'b1);
    if (rspValid) begin
      checkOutput({tag, " data"}, rspRdata, want);
      checkOutput({tag, " latency"}, lat, expLat);
    end
  endtask

  localparam logic [127:0] W1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] W2 = 128'hC4C4C4C4_C3C3C3C3_C2C2C2C2_C1C1C1C1;
  localparam logic [127:0] W3 = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
  localparam logic [127:0] SC = 128'h00000000_00000000_00000000_DEADBEEF;

  initial begin
    int sc;
    int snapAcc;
    int snapRsp;

    // Reset state
    @(negedge clk);
    #1;
    checkOutput("reset mem_we", memWe, 1'b0);
    checkOutput("reset mem_addr", memAddr, 16'h0);
    checkOutput("reset mem_wdata", memWdata, 32'h0);
    checkOutput("reset rsp_valid", rspValid, 1'b0);
    checkOutput("reset rsp_rdata", rspRdata, 128'h0);
    checkOutput("reset stall", stall, 1'b0);
    checkOutput("reset req_ready", reqReady, 1'b1);
    @(negedge clk);
    rstN = 1'b1;

    // Sentinels in the words a later aborted store must not reach
    applyStimulus("sent32", 1'b1, 1'b0, 16'h0032, 128'hA5A5A5A5, 128'h0, 1, sc);
    applyStimulus("sent33", 1'b1, 1'b0, 16'h0033, 128'h5A5A5A5A, 128'h0, 1, sc);

    // Reset in the middle of a vector store, after two beats
    @(negedge clk);
    reqWe = 1'b1; reqVf = 1'b1; reqAddr = 16'h0030; reqWdata = W2; reqValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    snapRsp = rspCnt;
    rstN = 1'b0;
    #1;
    checkOutput("midrst mem_we", memWe, 1'b0);
    checkOutput("midrst stall", stall, 1'b0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("midrst no rsp", rspCnt - snapRsp, 0);
    checkOutput("midrst ram30", ram[16'h0030], 32'hC1C1C1C1);
    checkOutput("midrst ram31", ram[16'h0031], 32'hC2C2C2C2);
    checkOutput("midrst ram32", ram[16'h0032], 32'hA5A5A5A5);
    checkOutput("midrst ram33", ram[16'h0033], 32'h5A5A5A5A);

    // Vector store then vector load of the same region
    applyStimulus("vst", 1'b1, 1'b1, 16'h0010, W1, 128'h0, 4, sc);
    checkOutput("vst ram10", ram[16'h0010], 32'h11111111);
    checkOutput("vst ram11", ram[16'h0011], 32'h22222222);
    checkOutput("vst ram12", ram[16'h0012], 32'h33333333);
    checkOutput("vst ram13", ram[16'h0013], 32'h44444444);
    applyStimulus("vld", 1'b0, 1'b1, 16'h0010, 128'h0, W1, 5, sc);
    checkOutput("vld stall cycles", sc, 5);

    // Scalar store and load; the store leaves rsp_rdata alone
    applyStimulus("sst", 1'b1, 1'b0, 16'h0020, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_DEADBEEF, W1, 1, sc);
    applyStimulus("sld", 1'b0, 1'b0, 16'h0020, 128'h0, SC, 2, sc);
    checkOutput("sld stall cycles", sc, 2);

    // Address wrap at the top of the word space
    applyStimulus("wst", 1'b1, 1'b1, 16'hFFFE, W3, SC, 4, sc);
    checkOutput("wrap ramFFFE", ram[16'hFFFE], 32'hAAAA0000);
    checkOutput("wrap ramFFFF", ram[16'hFFFF], 32'hBBBB0001);
    checkOutput("wrap ram0000", ram[16'h0000], 32'hCCCC0002);
    checkOutput("wrap ram0001", ram[16'h0001], 32'hDDDD0003);
    applyStimulus("wld", 1'b0, 1'b1, 16'hFFFE, 128'h0, W3, 5, sc);

    // req_valid held high: scalar store takes IDLE, WRITE, DONE per request
    @(negedge clk);
    snapAcc = accCnt;
    snapRsp = rspCnt;
    reqWe = 1'b1; reqVf = 1'b0; reqAddr = 16'h0040; reqWdata = 128'h0BADF00D; reqValid = 1'b1;
    repeat (12) @(negedge clk);
    reqValid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("hold accepts", accCnt - snapAcc, 4);
    checkOutput("hold responses", rspCnt - snapRsp, 4);
    checkOutput("hold ram40", ram[16'h0040], 32'h0BADF00D);
    checkOutput("queue empty", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
